// File: rtl/neosd_pkg.sv
`default_nettype none
// ============================================================================
// Module : neosd_pkg
// Brief  : Shared NEOSD definitions: slave register map, Wishbone initiator
//          FSM state encoding and the default bus timeout.
// Rev    : 1.0  initial release
// ============================================================================
package neosd_pkg;

  // NEOSD slave register byte offsets
  localparam logic [31:0] c_REG_CTRL     = 32'h0000_0000;
  localparam logic [31:0] c_REG_STAT     = 32'h0000_0004;
  localparam logic [31:0] c_REG_IRQ_FLAG = 32'h0000_0008;
  localparam logic [31:0] c_REG_IRQ_MASK = 32'h0000_000C;
  localparam logic [31:0] c_REG_CMDARG   = 32'h0000_0010;
  localparam logic [31:0] c_REG_CMD      = 32'h0000_0014;
  localparam logic [31:0] c_REG_RESP0    = 32'h0000_0018;
  localparam logic [31:0] c_REG_RESP1    = 32'h0000_001C;
  localparam logic [31:0] c_REG_RESP2    = 32'h0000_0020;
  localparam logic [31:0] c_REG_RESP3    = 32'h0000_0024;
  localparam logic [31:0] c_REG_DATA     = 32'h0000_0028;

  // Cycles a bus cycle may stay open without ack/err before it is abandoned
  localparam int unsigned c_WB_TIMEOUT_DEFAULT = 255;

  // Wishbone initiator states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } wb_init_state_t;

endpackage : neosd_pkg
`default_nettype wire

// File: rtl/neosd_wb_initiator.sv
`default_nettype none
// ============================================================================
// Module : neosd_wb_initiator
// Brief  : Single-outstanding pipelined-Wishbone initiator. Turns valid/ready
//          register requests into bus cycles and returns read data plus an
//          ack / err / timeout completion status.
// Rev    : 1.0  initial release
// ============================================================================
module neosd_wb_initiator
  import neosd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = c_WB_TIMEOUT_DEFAULT,
  parameter int unsigned TMO_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  // request side
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_adr_i,
  input  logic [31:0] req_dat_i,
  input  logic        req_we_i,
  input  logic [3:0]  req_sel_i,
  // response side
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        rsp_tmo_o,
  input  logic        abort_i,
  // Wishbone master port
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_stall_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic [31:0] wb_dat_i
);

  wb_init_state_t    state_q, state_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;

  logic [31:0]       wb_adr_q, wb_adr_d;
  logic [31:0]       wb_dat_q, wb_dat_d;
  logic              wb_we_q,  wb_we_d;
  logic [3:0]        wb_sel_q, wb_sel_d;
  logic              wb_stb_q, wb_stb_d;
  logic              wb_cyc_q, wb_cyc_d;

  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_dat_q,   rsp_dat_d;
  logic              rsp_err_q,   rsp_err_d;
  logic              rsp_tmo_q,   rsp_tmo_d;

  // Last permitted cycle of an open bus cycle; without ack/err it times out.
  logic              tmo_last;
  assign tmo_last = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // State register, timeout counter and all registered outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      tmo_cnt_q   <= '0;
      wb_adr_q    <= '0;
      wb_dat_q    <= '0;
      wb_we_q     <= 1'b0;
      wb_sel_q    <= '0;
      wb_stb_q    <= 1'b0;
      wb_cyc_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_cnt_q   <= tmo_cnt_d;
      wb_adr_q    <= wb_adr_d;
      wb_dat_q    <= wb_dat_d;
      wb_we_q     <= wb_we_d;
      wb_sel_q    <= wb_sel_d;
      wb_stb_q    <= wb_stb_d;
      wb_cyc_q    <= wb_cyc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tmo_q   <= rsp_tmo_d;
    end
  end

  // Next-state logic. Bus completion beats abort, abort beats timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req_valid_i) state_d = REQ;
      REQ: begin
        if (abort_i || tmo_last) state_d = RESP;
        else if (!wb_stall_i)    state_d = WAIT;
      end
      WAIT: begin
        if (wb_ack_i || wb_err_i || abort_i || tmo_last) state_d = RESP;
      end
      RESP: if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values; counter restarts on each new request.
  always_comb begin
    tmo_cnt_d   = tmo_cnt_q;
    wb_adr_d    = wb_adr_q;
    wb_dat_d    = wb_dat_q;
    wb_we_d     = wb_we_q;
    wb_sel_d    = wb_sel_q;
    wb_stb_d    = wb_stb_q;
    wb_cyc_d    = wb_cyc_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    rsp_tmo_d   = rsp_tmo_q;
    unique case (state_q)
      IDLE: begin
        tmo_cnt_d = '0;
        if (req_valid_i) begin
          wb_adr_d = req_adr_i;
          wb_dat_d = req_dat_i;
          wb_we_d  = req_we_i;
          wb_sel_d = req_sel_i;
          wb_stb_d = 1'b1;
          wb_cyc_d = 1'b1;
        end
      end
      REQ: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (abort_i) begin
          wb_stb_d    = 1'b0;
          wb_cyc_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = '0;
        end else if (tmo_last) begin
          wb_stb_d    = 1'b0;
          wb_cyc_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_tmo_d   = 1'b1;
          rsp_dat_d   = '0;
        end else if (!wb_stall_i) begin
          wb_stb_d = 1'b0;
        end
      end
      WAIT: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (wb_err_i) begin
          wb_cyc_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = '0;
        end else if (wb_ack_i) begin
          wb_cyc_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = wb_we_q ? 32'h0 : wb_dat_i;
        end else if (abort_i) begin
          wb_cyc_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = '0;
        end else if (tmo_last) begin
          wb_cyc_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_tmo_d   = 1'b1;
          rsp_dat_d   = '0;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b0;
          rsp_tmo_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign req_ready_o = (state_q == IDLE);
  assign wb_adr_o    = wb_adr_q;
  assign wb_dat_o    = wb_dat_q;
  assign wb_we_o     = wb_we_q;
  assign wb_sel_o    = wb_sel_q;
  assign wb_stb_o    = wb_stb_q;
  assign wb_cyc_o    = wb_cyc_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_tmo_o   = rsp_tmo_q;

endmodule : neosd_wb_initiator
`default_nettype wire
